// File: rtl/regfile_8x16_wrdec.sv
// regfile_8x16_wrdec
// Eight-entry register file for the decode stage. The 3-bit write ID coming
// from the destination mux is decoded into one-hot write enables; two
// independent combinational read ports return register contents.
//
// Optional feature: define RF_BYPASS_EN to forward writeData to a read port
// whose select matches the active write target in the same cycle. With the
// macro undefined, reads always return stored contents.
//
// R0 is an ordinary register (not hardwired to zero). Reset is synchronous,
// active-high, and takes priority over a simultaneous write.

module regfile_8x16_wrdec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       read1RegSel,
  input  logic [2:0]       read2RegSel,
  input  logic [2:0]       writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic             err
);

  localparam int NREGS = 8;

  // Storage for R0..R7.
  logic [WIDTH-1:0] r_regs [NREGS];

  // One-hot write enables from the write-ID decoder.
  logic [NREGS-1:0] w_we;

  // Stored contents selected by each read port, before any forwarding.
  logic [WIDTH-1:0] w_rd1_stored;
  logic [WIDTH-1:0] w_rd2_stored;

  // Decode the write ID: exactly one enable when writeEn is high, none otherwise.
  always_comb begin
    w_we = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_we[i] = writeEn && (writeRegSel == 3'(i));
    end
  end

  // Register update: reset clears everything and discards any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= writeData;
        end
      end
    end
  end

  assign w_rd1_stored = r_regs[read1RegSel];
  assign w_rd2_stored = r_regs[read2RegSel];

`ifdef RF_BYPASS_EN
  // Per-port forwarding hit: the port reads the register being written now.
  // Deliberately not gated by rst, so forwarding stays visible during reset
  // even though the register itself clears.
  logic w_byp1;
  logic w_byp2;

  assign w_byp1 = writeEn && (read1RegSel == writeRegSel);
  assign w_byp2 = writeEn && (read2RegSel == writeRegSel);

  // Read muxes with write-to-read forwarding.
  always_comb begin
    read1Data = w_byp1 ? writeData : w_rd1_stored;
    read2Data = w_byp2 ? writeData : w_rd2_stored;
  end
`else
  // Read muxes: stored contents only, no path from writeData.
  always_comb begin
    read1Data = w_rd1_stored;
    read2Data = w_rd2_stored;
  end
`endif

  // Input sanity: flag unknown control/select bits. Informational only; it
  // never gates the write path. Reduces to constant 0 in hardware.
  always_comb begin
    err = $isunknown({writeEn, writeRegSel, read1RegSel, read2RegSel});
  end

endmodule

// File: tb/tb_regfile_8x16_wrdec.sv
// Self-checking bench for regfile_8x16_wrdec.
// Behavioural model: an array of eight words updated per the write/reset rules,
// reads computed by direct indexing (plus forwarding when RF_BYPASS_EN).
// Expected read pairs go through exp_q; a compare process pops one per cycle.

module tb_regfile_8x16_wrdec;

  localparam int WIDTH = 16;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst;
  logic [2:0]       read1RegSel;
  logic [2:0]       read2RegSel;
  logic [2:0]       writeRegSel;
  logic [WIDTH-1:0] writeData;
  logic             writeEn;
  logic [WIDTH-1:0] read1Data;
  logic [WIDTH-1:0] read2Data;
  logic             err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_8x16_wrdec #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .err         (err)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0]   model [8];
  logic [2*WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Model of what a read port must return given current inputs and state.
  function automatic logic [WIDTH-1:0] model_read(input logic [2:0] s);
`ifdef RF_BYPASS_EN
    if (writeEn && (s == writeRegSel)) return writeData;
`endif
    return model[s];
  endfunction

  // Model state update on each rising edge: reset wins, else one write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) model[i] <= '0;
    end else if (writeEn) begin
      model[writeRegSel] <= writeData;
    end
  end

  // Compare process: one expected pair per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2*WIDTH-1:0] e;
      e = exp_q.pop_front();
      check("rd1_model", read1Data, e[2*WIDTH-1:WIDTH]);
      check("rd2_model", read2Data, e[WIDTH-1:0]);
      check("err_clean", {15'd0, err}, 16'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic r, input logic we, input logic [2:0] ws,
                             input logic [WIDTH-1:0] wd,
                             input logic [2:0] s1, input logic [2:0] s2);
    @(posedge clk);
    #1;
    rst = r; writeEn = we; writeRegSel = ws; writeData = wd;
    read1RegSel = s1; read2RegSel = s2;
    exp_q.push_back({model_read(s1), model_read(s2)});
  endtask

  task automatic write_reg(input logic [2:0] ws, input logic [WIDTH-1:0] wd);
    drive_cycle(1'b0, 1'b1, ws, wd, 3'd0, 3'd0);
  endtask

  // Idle read cycle followed by literal checks at mid-cycle.
  task automatic read_check(input string name, input logic [2:0] s1,
                            input logic [2:0] s2, input logic [WIDTH-1:0] e1,
                            input logic [WIDTH-1:0] e2);
    drive_cycle(1'b0, 1'b0, 3'd0, 16'h0000, s1, s2);
    @(negedge clk);
    check({name, "_p1"}, read1Data, e1);
    check({name, "_p2"}, read2Data, e2);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; writeEn = 1'b0; writeRegSel = 3'd0; writeData = '0;
    read1RegSel = 3'd0; read2RegSel = 3'd0;
    for (int i = 0; i < 8; i++) model[i] = '0;

    drive_cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd1);
    drive_cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'd2, 3'd3);

    // Reset clears a fully written file.
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'hFFFF);
    read_check("pre_rst", 3'd2, 3'd5, 16'hFFFF, 16'hFFFF);
    drive_cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      read_check("after_rst", 3'(i), 3'(7 - i), 16'h0000, 16'h0000);
      check("after_rst_err", {15'd0, err}, 16'd0);
    end

    // Decoder sweep.
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 8; i++)
      read_check("sweep", 3'(i), 3'(i), 16'h1000 + 16'(i), 16'h1000 + 16'(i));
    write_reg(3'd3, 16'h7777);
    read_check("r3_neighbors", 3'd2, 3'd4, 16'h1002, 16'h1004);
    read_check("r3_value", 3'd3, 3'd3, 16'h7777, 16'h7777);

    // writeEn low must not write.
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, 3'd5, 16'hBEEF, 3'd5, 3'd1);
    read_check("we_low", 3'd5, 3'd5, 16'h1005, 16'h1005);

    // Same-cycle read/write of R6.
    write_reg(3'd6, 16'h1234);
    drive_cycle(1'b0, 1'b1, 3'd6, 16'hABCD, 3'd6, 3'd6);
    @(negedge clk);
`ifdef RF_BYPASS_EN
    check("same_cycle_p1", read1Data, 16'hABCD);
    check("same_cycle_p2", read2Data, 16'hABCD);
`else
    check("same_cycle_p1", read1Data, 16'h1234);
    check("same_cycle_p2", read2Data, 16'h1234);
`endif
    read_check("same_cycle_after", 3'd6, 3'd6, 16'hABCD, 16'hABCD);

    // Back-to-back writes: last one retained.
    write_reg(3'd1, 16'h0A0A);
    write_reg(3'd1, 16'h0B0B);
    read_check("b2b", 3'd1, 3'd0, 16'h0B0B, 16'h1000);

    // Reset beats a simultaneous write.
    drive_cycle(1'b1, 1'b1, 3'd7, 16'h5555, 3'd0, 3'd0);
    read_check("rst_vs_wr", 3'd7, 3'd6, 16'h0000, 16'h0000);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 400; n++) begin
      drive_cycle(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    drive_cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);

    // err: unknown select bit, then clean inputs.
    @(posedge clk);
    #1;
    writeEn = 1'b0; writeRegSel = 3'b1x0;
    @(negedge clk);
    check("err_x", {15'd0, err},
          $isunknown({writeEn, writeRegSel, read1RegSel, read2RegSel}) ? 16'd1 : 16'd0);
    @(posedge clk);
    #1;
    writeRegSel = 3'd2;
    @(negedge clk);
    check("err_known", {15'd0, err}, 16'd0);

    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL exp_q_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
